// File: rtl/busca_instrucao_pkg.sv
// busca_instrucao_pkg
//   Definitions shared by the fetch stage and the control logic downstream:
//   fetch FSM state encoding, the halt opcode and the bit positions of the
//   opcode / Rx / Ry fields inside a 16-bit instruction word.
//   Optional feature macro used by the fetch stage: BUSCA_PREFETCH_EN.
package busca_instrucao_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StFetch = 3'd1,
        StWait  = 3'd2,
        StExec  = 3'd3,
        StHalt  = 3'd4
    } fetch_state_e;

    localparam int unsigned OPC_W = 3;
    localparam logic [OPC_W-1:0] OPC_HALT = 3'b111;

    // Field positions inside iin, shared with the control logic.
    localparam int unsigned OPC_MSB = 15;
    localparam int unsigned OPC_LSB = 13;
    localparam int unsigned RX_MSB  = 12;
    localparam int unsigned RX_LSB  = 10;
    localparam int unsigned RY_MSB  = 9;
    localparam int unsigned RY_LSB  = 7;

    function automatic logic is_halt(input logic [OPC_W-1:0] opc);
        return opc == OPC_HALT;
    endfunction

endpackage

// File: rtl/busca_instrucao_if.sv
// busca_instrucao_if
//   Synchronous-read instruction memory bus between the fetch stage and the
//   external memory. Read data is valid the cycle after mem_rd.
//   Signals:
//     mem_rd   - read strobe (fetch -> memory)
//     mem_addr - read address (fetch -> memory)
//     mem_data - read data (memory -> fetch)
//   Modports: master (fetch side), slave (memory side).
interface busca_instrucao_if #(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned INSTR_W = 16
);

    logic               mem_rd;
    logic [ADDR_W-1:0]  mem_addr;
    logic [INSTR_W-1:0] mem_data;

    modport master (
        output mem_rd,
        output mem_addr,
        input  mem_data
    );

    modport slave (
        input  mem_rd,
        input  mem_addr,
        output mem_data
    );

endinterface

// File: rtl/busca_instrucao_registrador.sv
// registrador_instrucao
//   Loadable register with synchronous active-high clear. Holds the current
//   instruction (iin) and, when prefetch is built in, the prefetched word.
//   Ports:
//     clock - clock, rising edge
//     clear - synchronous clear to zero, dominates load
//     load  - capture d on the next rising edge
//     d     - data in
//     q     - registered data out
module registrador_instrucao #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clock) begin
        if (clear) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/busca_instrucao.sv
// busca_instrucao
//   Instruction fetch stage. Walks pc through an external synchronous-read
//   memory, latches each word into iin and holds it until the control logic
//   pulses done. Opcode 3'b111 halts fetching until clear.
//   Optional feature macro: BUSCA_PREFETCH_EN adds a one-entry prefetch
//   buffer that is filled while an instruction executes, so a done with the
//   buffer full loads the next word with no iin_valid bubble.
//   Ports:
//     clock     - clock, rising edge
//     clear     - synchronous active-high reset, dominates every input
//     run       - enable fetching (sampled in IDLE and with done)
//     done      - control logic finished the current iin (one-cycle pulse)
//     mem       - memory bus, master side (mem_rd / mem_addr / mem_data)
//     iin       - instruction register
//     iin_valid - iin holds an instruction to execute
//     pc        - address of the next word to be latched
//     halted    - a halt opcode was fetched
module busca_instrucao
    import busca_instrucao_pkg::*;
#(
    parameter int unsigned ADDR_W  = 8,
    parameter int unsigned INSTR_W = 16
) (
    input  logic               clock,
    input  logic               clear,
    input  logic               run,
    input  logic               done,
    busca_instrucao_if.master  mem,
    output logic [INSTR_W-1:0] iin,
    output logic               iin_valid,
    output logic [ADDR_W-1:0]  pc,
    output logic               halted
);

    fetch_state_e       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               iin_load;
    logic [INSTR_W-1:0] iin_next;
    logic [INSTR_W-1:0] iin_q;
    logic               rd;

    registrador_instrucao #(
        .WIDTH(INSTR_W)
    ) u_iin (
        .clock(clock),
        .clear(clear),
        .load (iin_load),
        .d    (iin_next),
        .q    (iin_q)
    );

`ifdef BUSCA_PREFETCH_EN
    // pf_land_q: a prefetch read was issued last cycle, so mem_data carries
    // the word now. pf_valid_q: the word is parked in pf_data.
    logic               pf_valid_q, pf_valid_d;
    logic               pf_land_q, pf_land_d;
    logic [INSTR_W-1:0] pf_data;
    logic               pf_hit;
    logic [INSTR_W-1:0] pf_word;

    registrador_instrucao #(
        .WIDTH(INSTR_W)
    ) u_pf (
        .clock(clock),
        .clear(clear),
        .load (pf_land_q),
        .d    (mem.mem_data),
        .q    (pf_data)
    );

    // A word landing this very cycle is as good as a buffered one: bypass it.
    assign pf_hit  = pf_valid_q | pf_land_q;
    assign pf_word = pf_valid_q ? pf_data : mem.mem_data;
`endif

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q    <= StIdle;
            pc_q       <= '0;
`ifdef BUSCA_PREFETCH_EN
            pf_valid_q <= 1'b0;
            pf_land_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
`ifdef BUSCA_PREFETCH_EN
            pf_valid_q <= pf_valid_d;
            pf_land_q  <= pf_land_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        iin_load   = 1'b0;
        iin_next   = mem.mem_data;
        rd         = 1'b0;
`ifdef BUSCA_PREFETCH_EN
        pf_valid_d = 1'b0;
        pf_land_d  = 1'b0;
`endif

        unique case (state_q)
            StIdle: begin
                if (run) begin
                    state_d = StFetch;
                end
            end

            StFetch: begin
                rd      = 1'b1;
                state_d = StWait;
            end

            StWait: begin
                // A halt word is not latched and does not advance pc.
                if (is_halt(mem.mem_data[OPC_MSB:OPC_LSB])) begin
                    state_d = StHalt;
                end else begin
                    iin_load = 1'b1;
                    pc_d     = pc_q + ADDR_W'(1);
                    state_d  = StExec;
                end
            end

            StExec: begin
`ifdef BUSCA_PREFETCH_EN
                if (!pf_hit) begin
                    rd = 1'b1;
                    // With done on the issue cycle the read is completed by
                    // WAIT instead of the buffer.
                    pf_land_d = !done;
                end
                pf_valid_d = pf_hit & !done;
                if (done) begin
                    if (!run) begin
                        // Buffer flushed; pc still addresses the unread word.
                        state_d = StIdle;
                    end else if (pf_hit) begin
                        if (is_halt(pf_word[OPC_MSB:OPC_LSB])) begin
                            state_d = StHalt;
                        end else begin
                            iin_load = 1'b1;
                            iin_next = pf_word;
                            pc_d     = pc_q + ADDR_W'(1);
                        end
                    end else begin
                        state_d = StWait;
                    end
                end
`else
                if (done) begin
                    state_d = run ? StFetch : StIdle;
                end
`endif
            end

            StHalt: begin
                state_d = StHalt;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Address always follows pc, so it is stable whenever no read is issued.
    assign mem.mem_rd   = rd;
    assign mem.mem_addr = pc_q;

    assign iin       = iin_q;
    assign iin_valid = (state_q == StExec);
    assign pc        = pc_q;
    assign halted    = (state_q == StHalt);

endmodule

// File: tb/tb_busca_instrucao.sv
// tb_busca_instrucao
//   Self-checking bench for busca_instrucao. Memory is modelled as a 256-word
//   synchronous-read array; expected instruction streams come from walking the
//   array from a start address until a halt opcode.
//   Build with +define+BUSCA_PREFETCH_EN to check the prefetch variant.
module tb_busca_instrucao;
    import busca_instrucao_pkg::*;

    localparam int unsigned AW = 8;
    localparam int unsigned IW = 16;

    logic          clock = 1'b0;
    logic          clear = 1'b1;
    logic          run   = 1'b0;
    logic          done  = 1'b0;
    logic [IW-1:0] iin;
    logic          iin_valid;
    logic [AW-1:0] pc;
    logic          halted;

    busca_instrucao_if #(.ADDR_W(AW), .INSTR_W(IW)) mem_bus ();

    busca_instrucao #(
        .ADDR_W (AW),
        .INSTR_W(IW)
    ) dut (
        .clock    (clock),
        .clear    (clear),
        .run      (run),
        .done     (done),
        .mem      (mem_bus),
        .iin      (iin),
        .iin_valid(iin_valid),
        .pc       (pc),
        .halted   (halted)
    );

    always #5 clock = ~clock;

    logic [IW-1:0] mem_arr [256];

    always @(posedge clock) begin
        if (mem_bus.mem_rd === 1'b1) mem_bus.mem_data <= mem_arr[mem_bus.mem_addr];
    end

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [IW-1:0] exp_q [$];
    int            exp_halt_pc;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        run   = 1'b0;
        done  = 1'b0;
        tick();
        tick();
        clear = 1'b0;
    endtask

    // Model: words are executed in address order (wrapping) until a halt word.
    task automatic build_model(input int start);
        logic [AW-1:0] a;
        exp_q.delete();
        exp_halt_pc = -1;
        for (int k = 0; k < 256; k++) begin
            a = AW'(start + k);
            if (mem_arr[a][15:13] == OPC_HALT) begin
                exp_halt_pc = int'(a);
                break;
            end
            exp_q.push_back(mem_arr[a]);
        end
    endtask

    task automatic load_test_program();
        for (int i = 0; i < 256; i++) mem_arr[i] = 16'h0000;
        mem_arr[0] = 16'hA01C;
        mem_arr[1] = 16'hA40A;
        mem_arr[2] = 16'h8000;
        mem_arr[3] = 16'hE000;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (iin_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check(tag, 32'(iin_valid), 32'd1);
    endtask

    task automatic wait_halted(input string tag);
        int n = 0;
        while (halted !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check(tag, 32'(halted), 32'd1);
    endtask

    task automatic pulse_done();
        done = 1'b1;
        tick();
        done = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int            rd_cnt;
        int            d;
        logic [IW-1:0] w;

        // ---------------- reset ----------------
        load_test_program();
        do_clear();
        check("rst iin", 32'(iin), 32'd0);
        check("rst iin_valid", 32'(iin_valid), 32'd0);
        check("rst mem_rd", 32'(mem_bus.mem_rd), 32'd0);
        check("rst mem_addr", 32'(mem_bus.mem_addr), 32'd0);
        check("rst pc", 32'(pc), 32'd0);
        check("rst halted", 32'(halted), 32'd0);
        tick();
        check("idle no rd", 32'(mem_bus.mem_rd), 32'd0);

        // ---------------- sequential run ----------------
        build_model(0);
        run = 1'b1;
        tick();
        check("startup fetch rd", 32'(mem_bus.mem_rd), 32'd1);
        check("startup fetch addr", 32'(mem_bus.mem_addr), 32'd0);
        tick();
        check("startup wait valid", 32'(iin_valid), 32'd0);
        tick();
        check("startup valid", 32'(iin_valid), 32'd1);
        check("seq iin 0", 32'(iin), 32'(exp_q[0]));
        check("seq pc 0", 32'(pc), 32'd1);
        for (int i = 1; i < exp_q.size(); i++) begin
            tick();
            tick();
            pulse_done();
`ifndef BUSCA_PREFETCH_EN
            check("seq gap n+1", 32'(iin_valid), 32'd0);
            tick();
            check("seq gap n+2", 32'(iin_valid), 32'd0);
            tick();
`endif
            check("seq valid", 32'(iin_valid), 32'd1);
            check($sformatf("seq iin %0d", i), 32'(iin), 32'(exp_q[i]));
            check($sformatf("seq pc %0d", i), 32'(pc), 32'(i + 1));
        end
        tick();
        tick();
        pulse_done();
        wait_halted("halt reached");
        check("halt pc", 32'(pc), 32'(exp_halt_pc));
        check("halt iin kept", 32'(iin), 32'(exp_q[exp_q.size() - 1]));
        check("halt iin_valid", 32'(iin_valid), 32'd0);
        rd_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            if (mem_bus.mem_rd === 1'b1) rd_cnt++;
            tick();
        end
        check("halt no rd", 32'(rd_cnt), 32'd0);
        check("halt sticky", 32'(halted), 32'd1);

        // ---------------- stall and run-off ----------------
        do_clear();
        run = 1'b1;
        wait_valid("stall start");
        rd_cnt = 0;
        for (int c = 0; c < 10; c++) begin
            check("stall iin", 32'(iin), 32'h0000A01C);
            if (mem_bus.mem_rd === 1'b1) rd_cnt++;
            tick();
        end
`ifdef BUSCA_PREFETCH_EN
        check("stall rd count", 32'(rd_cnt), 32'd1);
`else
        check("stall rd count", 32'(rd_cnt), 32'd0);
`endif
        run = 1'b0;
        pulse_done();
        check("runoff iin_valid", 32'(iin_valid), 32'd0);
        check("runoff pc", 32'(pc), 32'd1);
        tick();
        tick();
        check("runoff idle rd", 32'(mem_bus.mem_rd), 32'd0);
        check("runoff idle valid", 32'(iin_valid), 32'd0);

        // ---------------- clear mid-WAIT ----------------
        do_clear();
        run = 1'b1;
        wait_valid("clr start");
        pulse_done();
`ifndef BUSCA_PREFETCH_EN
        tick();
`endif
        check("clr in wait", 32'(iin_valid), 32'd0);
        clear = 1'b1;
        run   = 1'b0;
        tick();
        clear = 1'b0;
        check("clr iin", 32'(iin), 32'd0);
        check("clr pc", 32'(pc), 32'd0);
        check("clr iin_valid", 32'(iin_valid), 32'd0);
        tick();
        tick();
        check("clr stale iin", 32'(iin), 32'd0);
        check("clr idle rd", 32'(mem_bus.mem_rd), 32'd0);

        // ---------------- randomized walk with pc wrap ----------------
        do_clear();
        for (int i = 0; i < 256; i++) begin
            w = IW'($urandom);
            if (w[15:13] == OPC_HALT) w[15] = 1'b0;
            mem_arr[i] = w;
        end
        mem_arr[255] = 16'hA01C;
        build_model(0);
        run = 1'b1;
        wait_valid("rnd start");
        check("rnd iin 0", 32'(iin), 32'(exp_q[0]));
        check("rnd pc 0", 32'(pc), 32'd1);
        for (int i = 1; i < exp_q.size(); i++) begin
            d = int'($urandom_range(0, 3));
            repeat (d) tick();
            pulse_done();
            wait_valid("rnd valid");
            check($sformatf("rnd iin %0d", i), 32'(iin), 32'(exp_q[i]));
            check($sformatf("rnd pc %0d", i), 32'(pc), 32'((i + 1) % 256));
        end
        check("wrap iin", 32'(iin), 32'h0000A01C);
        check("wrap pc", 32'(pc), 32'd0);
        run = 1'b0;
        pulse_done();
        check("wrap idle", 32'(iin_valid), 32'd0);
        check("wrap pc idle", 32'(pc), 32'd0);

`ifdef BUSCA_PREFETCH_EN
        // ---------------- prefetch back-to-back ----------------
        do_clear();
        for (int i = 0; i < 16; i++) mem_arr[i] = IW'(16'h1000 + i);
        build_model(0);
        run = 1'b1;
        wait_valid("pf start");
        for (int i = 0; i < 6; i++) begin
            check($sformatf("pf iin %0d", i), 32'(iin), 32'(exp_q[i]));
            check($sformatf("pf pc %0d", i), 32'(pc), 32'(i + 1));
            check("pf valid c0", 32'(iin_valid), 32'd1);
            tick();
            check("pf valid c1", 32'(iin_valid), 32'd1);
            tick();
            check("pf valid c2", 32'(iin_valid), 32'd1);
            pulse_done();
        end
        check("pf early iin", 32'(iin), 32'(exp_q[6]));
        done = 1'b1;
        tick();
        done = 1'b0;
        check("pf early gap", 32'(iin_valid), 32'd0);
        check("pf early iin held", 32'(iin), 32'(exp_q[6]));
        tick();
        check("pf early valid", 32'(iin_valid), 32'd1);
        check("pf early next iin", 32'(iin), 32'(exp_q[7]));
        check("pf early pc", 32'(pc), 32'd8);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/busca_instrucao.md
# busca_instrucao

Instruction fetch stage that sits directly upstream of the control logic. It walks a program counter through a synchronous-read instruction memory and latches each 16-bit word into an instruction register. It presents the word as `iin` to the control logic and advances only when the control logic signals completion. Opcode `3'b111` is a halt that freezes fetching until reset.

## Interface
- `ADDR_W`, default 8: program counter and memory address width.
- `INSTR_W`, default 16: instruction width. Opcode is `iin[15:13]`, Rx is `iin[12:10]`, Ry is `iin[9:7]`.
- `clock`, in, 1: single clock. All state updates on the rising edge.
- `clear`, in, 1: synchronous, active-high reset.
- `run`, in, 1: enable fetching. Sampled only in IDLE and on a `done` edge.
- `done`, in, 1: control logic has finished the current `iin`. One-cycle pulse.
- `mem_rd`, out, 1: memory read strobe.
- `mem_addr`, out, ADDR_W: read address.
- `mem_data`, in, INSTR_W: read data, valid the cycle after `mem_rd`.
- `iin`, out, INSTR_W: instruction register.
- `iin_valid`, out, 1: `iin` holds an instruction to execute.
- `pc`, out, ADDR_W: address of the next word to be latched.
- `halted`, out, 1: a halt opcode was fetched.

## Operation
- States: IDLE, FETCH, WAIT, EXEC, HALT.
- IDLE
  - `run`=1 → FETCH.
  - Otherwise stay in IDLE.
- FETCH: `mem_rd`=1, `mem_addr`=`pc` → WAIT.
- WAIT: capture `mem_data`.
  - Opcode 111 → HALT. `pc` and `iin` are unchanged.
  - Any other opcode: `iin`←`mem_data`, `pc`←`pc`+1 → EXEC.
- EXEC: `iin_valid`=1. `iin` is stable until `done`.
  - `done`=1 and `run`=1 → FETCH.
  - `done`=1 and `run`=0 → IDLE.
  - `done`=0 → stay in EXEC.
- HALT: `halted`=1. Leaves only on `clear`.
- `done` outside EXEC is ignored.
- `pc` wraps modulo 2^ADDR_W with no flag: `pc`=8'hFF increments to 8'h00.
- `mem_rd` is 0 in every state except FETCH, and in the prefetch slot described under Configuration.

## Timing
- Reset values: state IDLE, `pc`=0, `iin`=0, `iin_valid`=0, `mem_rd`=0, `mem_addr`=0, `halted`=0.
- `clear` wins over every other input on the same edge, including mid-read and mid-EXEC.
- After a `clear` that interrupts a read, the in-flight `mem_data` is discarded.
- Startup: `run` sampled at edge k gives FETCH in cycle k+1, WAIT in k+2, and `iin_valid`=1 from k+3.
- Between instructions without prefetch: `done` at edge n gives `iin_valid`=0 in cycles n+1 and n+2, and the new `iin` is valid from n+3.
- `mem_addr` holds `pc` in every cycle, so it is stable while `mem_rd`=0.

## Configuration
- Macro `BUSCA_PREFETCH_EN`.
- Defined: a one-entry prefetch buffer (`pf_data`, `pf_valid`) is added.
  - In EXEC with `pf_valid`=0 and no read in flight, issue `mem_rd` at `pc`. Capture the data into the buffer the next cycle.
  - `done` with `pf_valid`=1, non-halt opcode: `iin`←`pf_data`, `pc`←`pc`+1, `pf_valid`←0. Stay in EXEC; `iin_valid` stays 1, so there is zero bubble.
  - `done` with `pf_valid`=1, halt opcode: → HALT.
  - `done` while the prefetch read is in flight: → WAIT, which uses the normal capture path.
  - `done` with `run`=0: flush the buffer, `pf_valid`←0, → IDLE. `pc` still addresses the unconsumed word.
- Undefined: no buffer. Behaviour is exactly as described under Operation.

## Structure
- Shared package holds:
  - state encoding;
  - `OPC_HALT`=3'b111;
  - opcode, Rx and Ry field bit positions, shared with the control logic.
- Natural sub-module: `registrador_instrucao`, the loadable instruction register with synchronous clear. It is reused for `pf_data`.
- Memory is external to this block.

## Test plan
Program used unless stated: mem[0]=16'hA01C, mem[1]=16'hA40A, mem[2]=16'h8000, mem[3]=16'hE000.
- Reset: `clear`=1 for 2 cycles → all outputs 0, state IDLE.
- Sequential run: `run`=1, `done` pulsed 2 cycles after each `iin_valid` rise.
  - `iin` sequence is A01C, A40A, 8000.
  - Then `halted`=1 with `pc`=3.
  - `mem_rd` never asserts after `halted`=1.
- Stall and run-off: hold `done`=0 for 10 cycles → `iin` is stable and `mem_rd`=0 throughout. Then drop `run` on the `done` edge → IDLE, `pc`=1.
- Wrap: preload `pc` to 8'hFF via the memory contents and a jump-free program, with mem[255]=16'hA01C → after latching, `pc`=8'h00.
- Clear mid-WAIT → next cycle `iin`=0, `pc`=0, IDLE. The stale `mem_data` is never latched.
- `BUSCA_PREFETCH_EN` defined: back-to-back `done` every 3 cycles.
  - `iin_valid` never drops.
  - `done` the cycle after EXEC entry, before the prefetch completes, takes the WAIT path with a 1-cycle `iin_valid` gap.
